// File: rtl/sha_block_assembler_448.sv
// sha_block_assembler_448
//
// Serial-to-parallel front end for the 448-bit message block store of the
// double SHA-256 datapath. It packs 14 big-endian 32-bit message words into
// one 448-bit block, pulses a one-cycle write strobe to the block memory, and
// holds the block until the consumer acknowledges it. The trailing 64 bits of
// the 512-bit SHA-256 block (padding/length) are produced elsewhere.
//
// Ports
//   CLK             rising-edge clock
//   RST             asynchronous active-low reset
//   flush           synchronous abort of a partial or held block
//   word_valid      word_in carries a message word
//   word_in         32-bit message word
//   word_ready      a word can be accepted this cycle (decoded from state)
//   block_out       assembled block, word 0 in [447:416], word 13 in [31:0]
//   block_write_en  one-cycle write strobe for the block memory
//   block_valid     complete block held, awaiting block_ack
//   block_ack       consumer has taken the block
//   word_count      words accepted into the current block, 0..14
//
// Build option
//   SHA_ASSEMBLER_BYTE_SWAP_EN  when defined, each accepted word is
//   byte-reversed before storage (little-endian sources such as Bitcoin
//   header fields). Handshake and timing are unchanged.

module sha_block_assembler_448 (
    input  logic         CLK,
    input  logic         RST,
    input  logic         flush,
    input  logic         word_valid,
    input  logic [31:0]  word_in,
    output logic         word_ready,
    output logic [447:0] block_out,
    output logic         block_write_en,
    output logic         block_valid,
    input  logic         block_ack,
    output logic [3:0]   word_count
);

    localparam int         WORDS      = 14;
    localparam int         WORD_W     = 32;
    localparam logic [3:0] COUNT_MAX  = 4'd14;
    localparam logic [3:0] COUNT_LAST = 4'd13;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic [31:0] word_store;

    assign accept = word_valid && word_ready;

`ifdef SHA_ASSEMBLER_BYTE_SWAP_EN
    assign word_store = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
`else
    assign word_store = word_in;
`endif

    // State register.
    // NOTE: every clocked assignment uses <= so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides both a word accept and block_ack.
    // NOTE: state_next is given a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && word_count == COUNT_LAST) state_next = FULL;
            FULL:    if (block_ack) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
        if (flush) state_next = COLLECT;
    end

    // Output decode: the only combinational output.
    always_comb begin
        word_ready = (state == COLLECT);
    end

    // Registered datapath and status outputs.
    // NOTE: block_out is a plain register bank, not a RAM, so it takes an
    // async reset to zero; between blocks it is never cleared, only
    // overwritten slot by slot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            block_out      <= '0;
            block_write_en <= 1'b0;
            block_valid    <= 1'b0;
            word_count     <= '0;
        end else begin
            block_write_en <= 1'b0;
            block_valid    <= (state_next == FULL);
            if (flush) begin
                word_count <= '0;
            end else if (state == FULL) begin
                if (block_ack) word_count <= '0;
            end else if (accept) begin
                for (int i = 0; i < WORDS; i++) begin
                    if (word_count == 4'(i)) begin
                        block_out[(WORDS-1-i)*WORD_W +: WORD_W] <= word_store;
                    end
                end
                if (word_count != COUNT_MAX) word_count <= word_count + 4'd1;
                // The strobe lands in the first FULL cycle, alongside the
                // completed block.
                if (word_count == COUNT_LAST) block_write_en <= 1'b1;
            end
        end
    end

endmodule
